// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: byte-lane RAM stores, raw word reads,
// a small memory-mapped I/O window and a sticky store-fault status.
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [1:0]  size,
  output logic [31:0] rd,
  output logic [31:0] io_out,
  output logic        fault,
  output logic [31:0] fault_addr
);

  // IO register word offsets (a[15:2])
  localparam logic [13:0] OFF_OUT    = 14'd0;
  localparam logic [13:0] OFF_CYCLES = 14'd1;
  localparam logic [13:0] OFF_STATUS = 14'd2;

  logic [31:0] mem [DEPTH];

  logic [31:0] cyclesR;
  logic [31:0] ioOutR;
  logic [31:0] faultAddrR;
  logic        faultR;

  logic        isRamS;
  logic        isIoS;
  logic        storeFaultS;
  logic        ramWeS;
  logic        ioWeS;
  logic [31:0] laneDataS;
  logic [3:0]  byteEnS;
  logic [31:0] ioRdS;

  function automatic logic [31:0] laneData(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] laneEnable(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Address decode, fault detection and store lane generation
  always_comb begin
    isRamS      = (a[31:AW+2] == '0);
    isIoS       = (a[31:16] == 16'hFFFF);
    storeFaultS = we && (misaligned(size, a[1:0]) || (!isRamS && !isIoS) ||
                         (isIoS && size != 2'b10));
    ramWeS      = we && isRamS && !storeFaultS;
    ioWeS       = we && isIoS && !storeFaultS;
    laneDataS   = laneData(size, wd);
    byteEnS     = laneEnable(size, a[1:0]);
  end

  // RAM byte-lane write port; a store overlapping reset is dropped
  always_ff @(posedge clk) begin
    if (ramWeS && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEnS[i]) begin
          mem[a[AW+1:2]][8*i +: 8] <= laneDataS[8*i +: 8];
        end
      end
    end
  end

  // IO registers, free-running counter and sticky fault state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyclesR    <= 32'd0;
      ioOutR     <= 32'd0;
      faultR     <= 1'b0;
      faultAddrR <= 32'd0;
    end else begin
      cyclesR <= cyclesR + 32'd1;
      if (ioWeS && a[15:2] == OFF_OUT) begin
        ioOutR <= wd;
      end
      // A faulting store is never a STATUS write, so set and clear are exclusive
      if (storeFaultS) begin
        faultR <= 1'b1;
        if (!faultR) begin
          faultAddrR <= a;
        end
      end else if (ioWeS && a[15:2] == OFF_STATUS && wd[0]) begin
        faultR <= 1'b0;
      end
    end
  end

  // Combinational read mux; byte offset bits are ignored for reads
  always_comb begin
    case (a[15:2])
      OFF_OUT:    ioRdS = ioOutR;
      OFF_CYCLES: ioRdS = cyclesR;
      OFF_STATUS: ioRdS = {31'd0, faultR};
      default:    ioRdS = 32'd0;
    endcase
    if (isRamS) begin
      rd = mem[a[AW+1:2]];
    end else if (isIoS) begin
      rd = ioRdS;
    end else begin
      rd = 32'd0;
    end
  end

  assign io_out     = ioOutR;
  assign fault      = faultR;
  assign fault_addr = faultAddrR;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// timing/reset sequences and randomized traffic against a behavioural model.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [1:0]  size;
  logic [31:0] rd;
  logic [31:0] io_out;
  logic        fault;
  logic [31:0] fault_addr;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .size(size),
    .rd(rd), .io_out(io_out), .fault(fault), .fault_addr(fault_addr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (RAM model covers byte addresses 0..255)
  logic [31:0] mMem [64];
  logic [31:0] mIo;
  logic [31:0] mFa;
  logic        mFault;
  logic [31:0] mCyc;

  always @(posedge clk or posedge reset) begin
    if (reset) mCyc <= 32'd0;
    else       mCyc <= mCyc + 32'd1;
  end

  typedef struct {
    bit          doWe;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  size;
    logic [31:0] readA;
    logic [31:0] expRd;
    logic        expFault;
    logic [31:0] expFa;
    logic [31:0] expIo;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic modelStore(input logic [31:0] ad, input logic [31:0] d, input logic [1:0] sz);
    bit inRam = ((ad >> (AW + 2)) == 0);
    bit inIo  = (ad[31:16] == 16'hFFFF);
    int w     = (ad >> 2) % 64;
    int k     = ad % 4;
    bit bad;
    bad = (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0) ||
          (!inRam && !inIo) || (inIo && sz != 2'd2);
    if (bad) begin
      if (!mFault) mFa = ad;
      mFault = 1'b1;
    end else if (inRam) begin
      case (sz)
        2'd0: mMem[w][8*k +: 8] = d[7:0];
        2'd1: begin
          mMem[w][8*k +: 8]     = d[7:0];
          mMem[w][8*k + 8 +: 8] = d[15:8];
        end
        default: mMem[w] = d;
      endcase
    end else begin
      if (ad[15:0] == 16'h0000) mIo = d;
      else if (ad[15:0] == 16'h0008 && d[0]) mFault = 1'b0;
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] ad);
    logic [15:0] off;
    off = ad[15:0] & 16'hFFFC;
    if ((ad >> (AW + 2)) == 0) return mMem[(ad >> 2) % 64];
    if (ad[31:16] != 16'hFFFF) return 32'd0;
    case (off)
      16'h0000: return mIo;
      16'h0004: return mCyc;
      16'h0008: return {31'd0, mFault};
      default:  return 32'd0;
    endcase
  endfunction

  // One cycle: optional store at the edge, then settle on a read address
  task automatic doOp(input bit w, input logic [31:0] ad, input logic [31:0] d,
                      input logic [1:0] sz, input logic [31:0] rdAddr);
    we = w; a = ad; wd = d; size = sz;
    @(posedge clk);
    if (w) modelStore(ad, d, sz);
    #1;
    we = 1'b0; a = rdAddr;
    #1;
  endtask

  function automatic logic [31:0] randAddr();
    int r = $urandom_range(0, 9);
    if (r < 6) return 32'($urandom_range(0, 255));
    if (r < 8) return 32'hFFFF0000 | 32'($urandom_range(0, 3) * 4) |
                      ($urandom_range(0, 5) == 0 ? 32'($urandom_range(1, 3)) : 32'd0);
    return 32'h80000000 | 32'($urandom_range(0, 32'h7FFFFFFF));
  endfunction

  logic [31:0] v1;
  logic [31:0] v2;
  logic [31:0] ra;

  initial begin
    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 2'd2, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 32'h0,        32'h0,        2'd0, 32'h11,       32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 32'h0,        32'h0,        2'd0, 32'h13,       32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
    tbl[3]  = '{1'b1, 32'h22,       32'h123456AB, 2'd0, 32'h20,       32'h00AB0000, 1'b0, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 32'h20,       32'hFFFFCAFE, 2'd1, 32'h20,       32'h00ABCAFE, 1'b0, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 32'h31,       32'h00001234, 2'd1, 32'h30,       32'h0,        1'b1, 32'h31,       32'h0};
    tbl[6]  = '{1'b1, 32'h42,       32'h00000055, 2'd2, 32'h40,       32'h0,        1'b1, 32'h31,       32'h0};
    tbl[7]  = '{1'b1, 32'hFFFF0008, 32'h1,        2'd2, 32'hFFFF0008, 32'h0,        1'b0, 32'h31,       32'h0};
    tbl[8]  = '{1'b1, 32'hFFFF0000, 32'h0000A5A5, 2'd2, 32'hFFFF0000, 32'h0000A5A5, 1'b0, 32'h31,       32'hA5A5};
    tbl[9]  = '{1'b1, 32'h80000000, 32'h77,       2'd2, 32'h80000000, 32'h0,        1'b1, 32'h80000000, 32'hA5A5};
    tbl[10] = '{1'b1, 32'hFFFF0008, 32'h1,        2'd2, 32'h0,        32'h0,        1'b0, 32'h80000000, 32'hA5A5};
    tbl[11] = '{1'b1, 32'h0,        32'h99,       2'd3, 32'h0,        32'h0,        1'b1, 32'h0,        32'hA5A5};
    tbl[12] = '{1'b1, 32'hFFFF0008, 32'h1,        2'd2, 32'hFFFF0008, 32'h0,        1'b0, 32'h0,        32'hA5A5};
    tbl[13] = '{1'b1, 32'hFFFF0000, 32'h11,       2'd0, 32'hFFFF0000, 32'h0000A5A5, 1'b1, 32'hFFFF0000, 32'hA5A5};
    tbl[14] = '{1'b1, 32'hFFFF0008, 32'h1,        2'd2, 32'hFFFF0008, 32'h0,        1'b0, 32'hFFFF0000, 32'hA5A5};

    for (int i = 0; i < 64; i++) mMem[i] = 32'd0;
    mIo = 32'd0; mFa = 32'd0; mFault = 1'b0;

    reset = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0; size = 2'd0;
    #1;
    check("reset_io_out", io_out, 32'd0);
    check("reset_fault", {31'd0, fault}, 32'd0);
    check("reset_fault_addr", fault_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    a = 32'hFFFF0004;
    @(posedge clk); #1;
    check("cycles_first_edge", rd, 32'd1);

    for (int i = 0; i < 64; i++) doOp(1'b1, 32'(i * 4), 32'd0, 2'd2, 32'd0);

    for (int i = 0; i < 15; i++) begin
      doOp(tbl[i].doWe, tbl[i].a, tbl[i].wd, tbl[i].size, tbl[i].readA);
      check($sformatf("vec%0d_rd", i), rd, tbl[i].expRd);
      check($sformatf("vec%0d_fault", i), {31'd0, fault}, {31'd0, tbl[i].expFault});
      check($sformatf("vec%0d_fault_addr", i), fault_addr, tbl[i].expFa);
      check($sformatf("vec%0d_io_out", i), io_out, tbl[i].expIo);
    end

    // Counter steps by one per cycle and ignores stores
    a = 32'hFFFF0004; #1;
    v1 = rd;
    @(posedge clk); #1;
    v2 = rd;
    check("cycles_step", v2, v1 + 32'd1);
    check("cycles_model", v2, mCyc);
    doOp(1'b1, 32'hFFFF0004, 32'h12345678, 2'd2, 32'hFFFF0004);
    check("cycles_nowrite", rd, mCyc);
    check("cycles_nowrite_fault", {31'd0, fault}, 32'd0);

    // Same-cycle read returns old data; new data visible next cycle
    we = 1'b1; a = 32'h10; wd = 32'h0BADF00D; size = 2'd2;
    #1;
    check("same_cycle_old", rd, 32'hDEADBEEF);
    @(posedge clk);
    modelStore(32'h10, 32'h0BADF00D, 2'd2);
    #1; we = 1'b0; #1;
    check("next_cycle_new", rd, 32'h0BADF00D);

    // Async reset between edges with a store in flight
    doOp(1'b1, 32'h80000000, 32'd0, 2'd2, 32'd0);
    check("pre_reset_fault", {31'd0, fault}, 32'd1);
    check("pre_reset_io", io_out, 32'h0000A5A5);
    we = 1'b1; a = 32'h10; wd = 32'hFFFFFFFF; size = 2'd2;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_io", io_out, 32'd0);
    check("async_reset_fault", {31'd0, fault}, 32'd0);
    check("async_reset_fault_addr", fault_addr, 32'd0);
    mIo = 32'd0; mFault = 1'b0; mFa = 32'd0;
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    a = 32'h10; #1;
    check("ram_kept_after_reset", rd, 32'h0BADF00D);
    a = 32'hFFFF0004;
    @(posedge clk); #1;
    check("cycles_after_reset", rd, 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ad;
      logic [1:0]  sz;
      ad = randAddr();
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (ad[31:16] == 16'hFFFF && $urandom_range(0, 1) == 1) sz = 2'd2;
      ra = randAddr();
      doOp($urandom_range(0, 3) != 0, ad, $urandom, sz, ra);
      check($sformatf("rand%0d_rd@%h", n, ra), rd, modelRead(ra));
      check($sformatf("rand%0d_fault", n), {31'd0, fault}, {31'd0, mFault});
      check($sformatf("rand%0d_fault_addr", n), fault_addr, mFa);
      check($sformatf("rand%0d_io_out", n), io_out, mIo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
